// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decode and the iterative multiply/divide unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_ITYPE = 2'b11;

    localparam logic [6:0] F7_M   = 7'b0000001;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_MUL  = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: operand magnitudes, one bit per step, sign fix-up.
// Shares one 2*XLEN accumulator: multiplier or dividend starts in the low half.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            special,
    output logic [XLEN-1:0] special_result,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES     = '1;

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opd;
    logic [2:0]        f3_q;
    logic              sign_q;
    logic              sign_r;
    logic [CW-1:0]     cnt;

    logic              sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, ovf;

    // Unsigned operands: a for MULHU/DIVU/REMU, b additionally for MULHSU.
    always_comb begin
        sgn_a = !(funct3[0] && (funct3[1] || funct3[2]));
        sgn_b = sgn_a && (funct3 != 3'b010);
        neg_a = sgn_a && op_a[XLEN-1];
        neg_b = sgn_b && op_b[XLEN-1];
        mag_a = neg_a ? -op_a : op_a;
        mag_b = neg_b ? -op_b : op_b;
    end

    always_comb begin
        div_zero = funct3[2] && (op_b == '0);
        ovf      = funct3[2] && !funct3[0] && (op_a == MIN_VAL) && (op_b == ONES);
        special  = div_zero || ovf;
        if (div_zero)
            special_result = funct3[1] ? op_a : ONES;
        else
            special_result = funct3[1] ? '0 : MIN_VAL;
    end

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge      = shifted >= {1'b0, opd};
        // When ge the true difference is below opd, so the low XLEN bits are exact.
        diff    = shifted[XLEN-1:0] - opd;
        if (f3_q[2])
            acc_next = {(ge ? diff : shifted[XLEN-1:0]), acc[XLEN-2:0], ge};
        else
            acc_next = {sum, acc[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        prod = sign_q ? -acc_next : acc_next;
        quo  = acc_next[XLEN-1:0];
        rem  = acc_next[2*XLEN-1:XLEN];
        if (!f3_q[2])
            result = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (!f3_q[1])
            result = sign_q ? -quo : quo;
        else
            result = sign_r ? -rem : rem;
    end

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            opd    <= '0;
            f3_q   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            opd    <= funct3[2] ? mag_b : mag_a;
            f3_q   <= funct3;
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
            cnt    <= '0;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decode plus RV32M sequencing: stalls the core while an M-op iterates.
module alu_mdu_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_ctl,
    output logic            is_mop,
    output logic            stall,
    output logic            mdu_valid,
    output logic [XLEN-1:0] mdu_result
);

    mdu_state_e      state;
    logic            valid_q;
    logic            start;
    logic            step;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic            last;
    logic [XLEN-1:0] iter_result;

    assign is_mop = EN_M && (alu_op == AOP_RTYPE) && (funct7 == F7_M);

    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            AOP_ADD: alu_ctl = ALU_ADD;
            AOP_SUB: alu_ctl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_ctl = (alu_op == AOP_RTYPE && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctl = ALU_SLL;
                    3'b010:  alu_ctl = ALU_SLT;
                    3'b011:  alu_ctl = ALU_SLTU;
                    3'b100:  alu_ctl = ALU_XOR;
                    3'b101:  alu_ctl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctl = ALU_OR;
                    default: alu_ctl = ALU_AND;
                endcase
            end
        endcase
        if (is_mop)
            alu_ctl = ALU_ADD;
    end

    // Handshake: stall holds PC and execute inputs; the core advances at the end
    // of the single DONE cycle, when stall is low and mdu_valid is high.
    assign start     = rst_n && valid_in && is_mop && !flush && (state == MDU_IDLE);
    assign step      = !flush && (state == MDU_MUL || state == MDU_DIV);
    assign stall     = rst_n && !flush && (start || state == MDU_MUL || state == MDU_DIV);
    assign mdu_valid = valid_q && !flush;

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (start),
        .step           (step),
        .funct3         (funct3),
        .op_a           (op_a),
        .op_b           (op_b),
        .special        (special),
        .special_result (special_result),
        .last           (last),
        .result         (iter_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MDU_IDLE;
            valid_q    <= 1'b0;
            mdu_result <= '0;
        end else if (flush) begin
            state   <= MDU_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        if (special) begin
                            mdu_result <= special_result;
                            valid_q    <= 1'b1;
                            state      <= MDU_DONE;
                        end else begin
                            state <= funct3[2] ? MDU_DIV : MDU_MUL;
                        end
                    end
                end
                MDU_MUL, MDU_DIV: begin
                    if (last) begin
                        mdu_result <= iter_result;
                        valid_q    <= 1'b1;
                        state      <= MDU_DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= MDU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl: decode sweep, M-op results/latency, flush and reset.
module tb_alu_mdu_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        flush;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_ctl;
    logic        is_mop;
    logic        stall;
    logic        mdu_valid;
    logic [31:0] mdu_result;

    int checks = 0;
    int errors = 0;

    alu_mdu_ctrl #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .flush      (flush),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_ctl    (alu_ctl),
        .is_mop     (is_mop),
        .stall      (stall),
        .mdu_valid  (mdu_valid),
        .mdu_result (mdu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hand-written code table for the base decode.
    function automatic logic [3:0] exp_ctl(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b10 && f7 == 7'b0000001) return 4'b0010;
        case (f3)
            3'b000:  return (op == 2'b10 && f7 == 7'b0100000) ? 4'b0110 : 4'b0010;
            3'b001:  return 4'b0100;
            3'b010:  return 4'b0111;
            3'b011:  return 4'b1000;
            3'b100:  return 4'b0011;
            3'b101:  return (f7 == 7'b0100000) ? 4'b1001 : 4'b0101;
            3'b110:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Called at a falling edge; presents an M-op and follows it to its DONE cycle.
    task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stalls;
        valid_in = 1'b1;
        flush    = 1'b0;
        alu_op   = 2'b10;
        funct7   = 7'b0000001;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        #1;
        check({tag, "_stall_T"}, 32'(stall), 32'd1);
        check({tag, "_valid_T"}, 32'(mdu_valid), 32'd0);
        lat    = 0;
        stalls = 1;
        while (mdu_valid !== 1'b1 && lat < 80) begin
            @(negedge clk);
            #1;
            lat++;
            if (stall === 1'b1) stalls++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_result"}, mdu_result, exp_res);
    endtask

    initial begin
        int seen;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        flush    = 1'b0;
        alu_op   = 2'b00;
        funct3   = 3'b000;
        funct7   = 7'b0000000;
        op_a     = '0;
        op_b     = '0;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_valid", 32'(mdu_valid), 32'd0);
        check("rst_result", mdu_result, 32'd0);
        check("rst_state", 32'(dut.state), 32'(MDU_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Base decode sweep; M combinations are presented without valid_in.
        for (int op = 0; op < 4; op++) begin
            for (int f3 = 0; f3 < 8; f3++) begin
                for (int k = 0; k < 3; k++) begin
                    logic [6:0] f7;
                    logic       mop;
                    f7  = (k == 0) ? 7'b0000000 : (k == 1) ? 7'b0100000 : 7'b0000001;
                    mop = (op == 2) && (k == 2);
                    @(negedge clk);
                    alu_op   = 2'(op);
                    funct3   = 3'(f3);
                    funct7   = f7;
                    valid_in = !mop;
                    op_a     = $urandom;
                    op_b     = $urandom;
                    #1;
                    check($sformatf("dec_ctl_%0d_%0d_%0d", op, f3, k), 32'(alu_ctl), 32'(exp_ctl(2'(op), 3'(f3), f7)));
                    check($sformatf("dec_mop_%0d_%0d_%0d", op, f3, k), 32'(is_mop), 32'(mop));
                    check($sformatf("dec_stall_%0d_%0d_%0d", op, f3, k), 32'(stall), 32'd0);
                end
            end
        end
        @(negedge clk);
        alu_op = 2'b10; funct3 = 3'b101; funct7 = 7'b0100000; valid_in = 1'b1;
        #1;
        check("dec_sra_spot", 32'(alu_ctl), 32'b1001);
        alu_op = 2'b11; funct3 = 3'b000; funct7 = 7'b0100000;
        #1;
        check("dec_addi_spot", 32'(alu_ctl), 32'b0010);
        check("dec_no_state", 32'(dut.state), 32'(MDU_IDLE));
        check("dec_no_result", mdu_result, 32'd0);
        valid_in = 1'b0;

        // Iterated ops: 33-cycle latency.
        @(negedge clk); run_mop("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        @(negedge clk); run_mop("mulhu_7_m3", 3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
        @(negedge clk); valid_in = 1'b0; #1;
        check("one_done_cycle", 32'(mdu_valid), 32'd0);
        @(negedge clk); run_mop("mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        @(negedge clk); run_mop("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        @(negedge clk); run_mop("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        @(negedge clk); run_mop("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        @(negedge clk); run_mop("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        @(negedge clk); run_mop("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        // Special cases: one stall cycle, result next cycle.
        @(negedge clk); run_mop("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        @(negedge clk); run_mop("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        @(negedge clk); run_mop("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        @(negedge clk); run_mop("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        @(negedge clk); run_mop("div_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1);

        // Flush at T+10 of a DIV.
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b1; alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b100;
        op_a = 32'd1000; op_b = 32'd3;
        #1;
        check("flush_div_start", 32'(stall), 32'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (mdu_valid === 1'b1) seen++;
        end
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_valid", 32'(mdu_valid), 32'd0);
        check("flush_no_valid_before", 32'(seen), 32'd0);
        @(negedge clk);
        check("flush_state_idle", 32'(dut.state), 32'(MDU_IDLE));
        check("flush_result_kept", mdu_result, 32'hFFFF_FFFF);
        run_mop("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Asynchronous reset mid-MUL.
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk);
        valid_in = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_valid", 32'(mdu_valid), 32'd0);
        check("arst_result", mdu_result, 32'd0);
        check("arst_state", 32'(dut.state), 32'(MDU_IDLE));
        @(negedge clk);
        rst_n = 1'b1; valid_in = 1'b0;
        @(negedge clk); run_mop("b2b_2x3", 3'b000, 32'd2, 32'd3, 32'd6, 33);
        @(negedge clk); run_mop("b2b_4x5", 3'b000, 32'd4, 32'd5, 32'd20, 33);
        @(negedge clk); valid_in = 1'b0; #1;
        check("b2b_single_done", 32'(mdu_valid), 32'd0);
        check("b2b_final_state", 32'(dut.state), 32'(MDU_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
- Next-generation ALU control block for the single-cycle core, parametrised in XLEN.
- Keeps the existing combinational alu_ctl decode for base RV32I ops.
- Adds RV32M support: an iterative multiply/divide unit (MDU) with an FSM and a stall handshake.
- Sits between the main decoder/register file and the ALU. It holds the pipeline while an M-op iterates, then returns the M result alongside the ALU result.

Parameters:
- XLEN, 32: operand/result width; must be ≥ 8 and a power of 2.
- EN_M, 1: 1 enables RV32M decode and the MDU. When 0, funct7=0000001 decodes as base ops and stall is tied low.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  instruction in the execute slot is valid.
- flush  in  1  synchronous abort of any in-flight M-op.
- alu_op  in  2  from the main decoder: 00 add, 01 branch sub, 10 R-type, 11 I-type.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- alu_ctl  out  4  ALU operation code (combinational).
- is_mop  out  1  current instruction is an M-op (combinational).
- stall  out  1  hold PC and execute inputs this cycle.
- mdu_valid  out  1  mdu_result is valid this cycle.
- mdu_result  out  XLEN  M-op result (registered).

Behaviour:
- alu_ctl codes: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 1001, SLT 0111, SLTU 1000.
- alu_ctl decode:
  - alu_op 00 → ADD; alu_op 01 → SUB.
  - R-type (10): funct3 decode; funct7=0100000 selects SUB (f3 000) or SRA (f3 101).
  - I-type (11): same decode, but f3 000 is always ADD; funct7 is checked only for f3 101.
  - Unknown combinations → ADD.
- is_mop = EN_M & alu_op==10 & funct7==0000001. While is_mop, alu_ctl = ADD (don't-care for the core).
- M-ops by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE. Reset → IDLE, mdu_valid=0, mdu_result=0, all internal registers 0.
- IDLE:
  - valid_in & is_mop & !flush → latch operands and f3; stall=1 combinationally.
  - Next state: DONE if a special case applies, else MUL (f3[2]=0) or DIV (f3[2]=1).
- Operand preparation:
  - Signed operands (MUL/MULH/DIV/REM: both; MULHSU: op_a only) are converted to magnitudes.
  - A sign flag is latched.
- MUL: unsigned shift-add, one multiplier bit per cycle, exactly XLEN cycles into a 2·XLEN accumulator. stall=1.
- DIV: restoring division, one quotient bit per cycle, exactly XLEN cycles. stall=1.
- After the final iteration: apply sign correction, load mdu_result, go to DONE.
  - MUL result = low half; MULH* result = high half.
  - Quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
- DONE: mdu_valid=1, stall=0 for exactly one cycle, then IDLE. The core advances past the instruction at the end of DONE, so the same instruction never restarts.
- Latency: accept at cycle T → mdu_valid at T+XLEN+1 for iterated ops, T+1 for special cases. stall is high T..T+XLEN, or for T only in special cases.
- Special cases (no iteration, go directly to DONE):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (op_a = MIN, op_b = −1): DIV → MIN; REM → 0.
- flush in any state → IDLE next cycle, mdu_valid=0, stall=0 in that cycle. mdu_result keeps its last value. flush overrides start in IDLE.
- valid_in low in IDLE: no start, stall=0. valid_in is ignored in MUL/DIV/DONE.
- rst_n assertion mid-operation: immediate return to IDLE with all outputs at reset values.
- Non-M instructions: stall=0, mdu_valid=0, no registered state changes.

Decomposition:
- Package alu_pkg:
  - alu_ctl localparams (the ten codes).
  - alu_op encodings.
  - M funct7 constant 0000001 and funct7 alt constant 0100000.
  - MDU state encoding.
- Sub-module mdu_iter: operand preparation, shift-add/restore datapath, iteration counter (clog2(XLEN)+1 bits) and sign correction.
- alu_mdu_ctrl: combinational decode, FSM, handshake.

Test Plan:
- Base decode sweep: every alu_op/funct3/funct7 combination with is_mop=0 → alu_ctl matches the code table; stall=0 throughout; e.g. 10/101/0100000 → 1001.
- MUL, op_a=7, op_b=−3 (XLEN=32) → stall high 33 cycles; mdu_valid at T+33; result 0xFFFFFFEB. Same operands with MULHU → 0x00000006.
- DIV, op_a=−7, op_b=2 → 0xFFFFFFFD (−3); REM with the same operands → 0xFFFFFFFF (−1); each with mdu_valid at T+33.
- DIVU by 0 with op_a=5 → 0xFFFFFFFF at T+1; REM 0x80000000 / 0xFFFFFFFF → 0 at T+1; stall high for one cycle only.
- flush asserted at cycle T+10 of a DIV → stall=0 the same cycle, state IDLE; mdu_valid never asserts; a new MUL of 3×4 accepted next cycle → 12.
- rst_n pulsed low mid-MUL → outputs reset asynchronously. After release, back-to-back MULs 2×3 and 4×5 → mdu_valid twice, results 6 then 20, exactly one DONE cycle each.
